// File: rtl/fp_mac_arb_pkg.sv
// Shared constants and the per-operation tag type for the shared FP multiply-add arbiter.
package fp_mac_arb_pkg;

    localparam int FP_W                = 32;
    localparam int MAC_LATENCY_DEFAULT = 4;
    localparam int TAG_ID_W            = 4;  // holds any index up to the 16-requester maximum

    typedef struct packed {
        logic                valid;
        logic [TAG_ID_W-1:0] id;
    } mac_tag_t;

endpackage

// File: rtl/FP_MUL_ADD.sv
// Single-precision multiply-add DSP (resulta = ax*ay + az): input registers plus LATENCY-1 output
// stages; denormals flush to zero, round to nearest even. LATENCY must be at least 2.
module FP_MUL_ADD #(
    parameter int LATENCY = 4
) (
    input  logic        clk,
    input  logic        ena,
    input  logic [1:0]  aclr,
    input  logic [31:0] ax,
    input  logic [31:0] ay,
    input  logic [31:0] az,
    output logic [31:0] resulta
);

    logic [31:0]        ax_q, ay_q, az_q, fma_res;
    logic [31:0]        res_pipe_q [LATENCY-1];
    logic               a_zero, b_zero, c_zero, a_max, b_max, c_max, any_nan, sp, sr, round_up;
    logic [23:0]        ma, mb, mc, mant;
    logic [24:0]        mant_r;
    logic [47:0]        prod;
    logic [75:0]        xp, xc, xp_al, xc_al, mag, norm;
    logic signed [11:0] ea_s, eb_s, ec_s, e_prod, e_add, emax, er;
    int                 lead;

    // Right shift that folds every bit shifted out into the LSB, keeping rounding exact.
    function automatic logic [75:0] align(input logic [75:0] x, input int sh);
        logic [75:0] y;
        if (sh >= 76) begin
            y = {75'd0, |x};
        end else begin
            y    = x >> sh;
            y[0] = y[0] | (|(x & ~({76{1'b1}} << sh)));
        end
        return y;
    endfunction

    always_comb begin
        ea_s    = $signed({4'd0, ax_q[30:23]});
        eb_s    = $signed({4'd0, ay_q[30:23]});
        ec_s    = $signed({4'd0, az_q[30:23]});
        a_zero  = (ax_q[30:23] == 8'd0);
        b_zero  = (ay_q[30:23] == 8'd0);
        c_zero  = (az_q[30:23] == 8'd0);
        a_max   = (ax_q[30:23] == 8'hFF);
        b_max   = (ay_q[30:23] == 8'hFF);
        c_max   = (az_q[30:23] == 8'hFF);
        sp      = ax_q[31] ^ ay_q[31];
        any_nan = (a_max && ax_q[22:0] != '0) || (b_max && ay_q[22:0] != '0) ||
                  (c_max && az_q[22:0] != '0) || (a_max && b_zero) || (b_max && a_zero) ||
                  ((a_max || b_max) && c_max && (sp != az_q[31]));
        ma      = a_zero ? 24'd0 : {1'b1, ax_q[22:0]};
        mb      = b_zero ? 24'd0 : {1'b1, ay_q[22:0]};
        mc      = c_zero ? 24'd0 : {1'b1, az_q[22:0]};
        prod    = {24'd0, ma} * {24'd0, mb};
        e_prod  = (a_zero || b_zero) ? ec_s : ea_s + eb_s - 12'sd127;
        e_add   = c_zero ? e_prod : ec_s;
        // Both terms share one fixed-point scale: LSB of the 48-bit product sits at bit 26.
        xp      = {2'b00, prod, 26'd0};
        xc      = {3'b000, mc, 49'd0};
        if (e_prod >= e_add) begin
            emax  = e_prod;
            xp_al = xp;
            xc_al = align(xc, int'(e_prod - e_add));
        end else begin
            emax  = e_add;
            xp_al = align(xp, int'(e_add - e_prod));
            xc_al = xc;
        end
        if (sp == az_q[31]) begin
            mag = xp_al + xc_al;
            sr  = sp;
        end else if (xp_al >= xc_al) begin
            mag = xp_al - xc_al;
            sr  = sp;
        end else begin
            mag = xc_al - xp_al;
            sr  = az_q[31];
        end
        lead = 0;
        for (int i = 0; i < 76; i++)
            if (mag[i]) lead = i;
        norm     = mag << (75 - lead);
        mant     = norm[75:52];
        round_up = norm[51] & ((|norm[50:0]) | norm[52]);
        mant_r   = {1'b0, mant} + {24'd0, round_up};
        er       = 12'(lead) + emax - 12'sd72 + (mant_r[24] ? 12'sd1 : 12'sd0);
        if (any_nan)                fma_res = 32'h7FC0_0000;
        else if (a_max || b_max)    fma_res = {sp, 8'hFF, 23'd0};
        else if (c_max)             fma_res = {az_q[31], 8'hFF, 23'd0};
        else if (mag == '0)         fma_res = '0;
        else if (er >= 12'sd255)    fma_res = {sr, 8'hFF, 23'd0};
        else if (er <= 12'sd0)      fma_res = {sr, 31'd0};
        else                        fma_res = {sr, er[7:0], mant_r[24] ? mant_r[23:1] : mant_r[22:0]};
    end

    always_ff @(posedge clk or posedge aclr[0]) begin
        if (aclr[0]) begin
            ax_q <= '0;
            ay_q <= '0;
            az_q <= '0;
        end else if (ena) begin
            ax_q <= ax;
            ay_q <= ay;
            az_q <= az;
        end
    end

    always_ff @(posedge clk or posedge aclr[1]) begin
        if (aclr[1]) begin
            for (int s = 0; s < LATENCY - 1; s++) res_pipe_q[s] <= '0;
        end else if (ena) begin
            res_pipe_q[0] <= fma_res;
            for (int s = 1; s < LATENCY - 1; s++) res_pipe_q[s] <= res_pipe_q[s-1];
        end
    end

    assign resulta = res_pipe_q[LATENCY-2];

endmodule

// File: rtl/fp_mac_rr_arbiter.sv
// Round-robin grant over NUM_REQ requesters; rr_ptr moves past the winner on every transfer.
module fp_mac_rr_arbiter #(
    parameter  int NUM_REQ  = 4,
    localparam int ID_WIDTH = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                aclr,
    input  logic [NUM_REQ-1:0]  req_valid,
    output logic [NUM_REQ-1:0]  grant,
    output logic                grant_vld,
    output logic [ID_WIDTH-1:0] grant_id
);

    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;

    // NOTE: every output gets a default before the search, so no path leaves one unassigned and no latch appears.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            automatic int idx = int'(rr_ptr_q) + i;
            if (idx >= NUM_REQ) idx -= NUM_REQ;
            if (!grant_vld && req_valid[idx] && !aclr) begin
                grant_vld  = 1'b1;
                grant_id   = ID_WIDTH'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld)
            rr_ptr_d = (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + ID_WIDTH'(1);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) rr_ptr_q <= '0;
        else      rr_ptr_q <= rr_ptr_d;
    end

endmodule

// File: rtl/fp_mac_arbiter.sv
// Shares one FP multiply-add DSP among NUM_REQ requesters, returning each result with its requester id.
// Optional FP_MAC_ARB_STATS_EN adds per-requester saturating issue counters on issue_count.
module fp_mac_arbiter
    import fp_mac_arb_pkg::*;
#(
    parameter  int NUM_REQ     = 4,
    parameter  int MAC_LATENCY = MAC_LATENCY_DEFAULT,
    localparam int ID_WIDTH    = $clog2(NUM_REQ)
) (
    input  logic                    clk,
    input  logic                    aclr,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [NUM_REQ*FP_W-1:0] req_ax,
    input  logic [NUM_REQ*FP_W-1:0] req_ay,
    input  logic [NUM_REQ*FP_W-1:0] req_az,
    output logic                    res_valid,
    output logic [ID_WIDTH-1:0]     res_id,
    output logic [FP_W-1:0]         res_data,
`ifdef FP_MAC_ARB_STATS_EN
    output logic [NUM_REQ*32-1:0]   issue_count,
`endif
    output logic                    mac_busy
);

    logic [NUM_REQ-1:0]  grant;
    logic                grant_vld;
    logic [ID_WIDTH-1:0] grant_id;
    logic [FP_W-1:0]     mux_ax, mux_ay, mux_az;
    mac_tag_t            tag_d;
    mac_tag_t            tag_q [MAC_LATENCY];
    logic                unused_tag_id;

    fp_mac_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk       (clk),
        .aclr      (aclr),
        .req_valid (req_valid),
        .grant     (grant),
        .grant_vld (grant_vld),
        .grant_id  (grant_id)
    );

    assign req_ready = grant;

    always_comb begin
        mux_ax = '0;
        mux_ay = '0;
        mux_az = '0;
        if (grant_vld) begin
            mux_ax = req_ax[int'(grant_id)*FP_W +: FP_W];
            mux_ay = req_ay[int'(grant_id)*FP_W +: FP_W];
            mux_az = req_az[int'(grant_id)*FP_W +: FP_W];
        end
    end

    always_comb begin
        tag_d       = '0;
        tag_d.valid = grant_vld;
        tag_d.id    = TAG_ID_W'(grant_id);
    end

    // NOTE: the tag pipeline is reset so an aclr pulse discards every in-flight operation.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int s = 0; s < MAC_LATENCY; s++) tag_q[s] <= '0;
        end else begin
            tag_q[0] <= tag_d;
            for (int s = 1; s < MAC_LATENCY; s++) tag_q[s] <= tag_q[s-1];
        end
    end

    assign res_valid     = tag_q[MAC_LATENCY-1].valid;
    assign res_id        = tag_q[MAC_LATENCY-1].id[ID_WIDTH-1:0];
    assign unused_tag_id = ^tag_q[MAC_LATENCY-1].id;

    always_comb begin
        mac_busy = 1'b0;
        for (int s = 0; s < MAC_LATENCY; s++) mac_busy |= tag_q[s].valid;
    end

    FP_MUL_ADD #(.LATENCY(MAC_LATENCY)) u_dsp (
        .clk     (clk),
        .ena     (1'b1),
        .aclr    ({aclr, aclr}),
        .ax      (mux_ax),
        .ay      (mux_ay),
        .az      (mux_az),
        .resulta (res_data)
    );

`ifdef FP_MAC_ARB_STATS_EN
    logic [31:0] issue_cnt_q [NUM_REQ];

    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            for (int r = 0; r < NUM_REQ; r++) issue_cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < NUM_REQ; r++)
                if (grant[r] && issue_cnt_q[r] != '1) issue_cnt_q[r] <= issue_cnt_q[r] + 32'd1;
        end
    end

    for (genvar r = 0; r < NUM_REQ; r++) begin : g_cnt
        assign issue_count[r*32 +: 32] = issue_cnt_q[r];
    end
`endif

endmodule

// File: tb/tb_fp_mac_arbiter.sv
// Directed bench for fp_mac_arbiter (4 requesters, latency 4); define FP_MAC_ARB_STATS_EN to cover the counters.
module tb_fp_mac_arbiter;

    logic         clk = 1'b0;
    logic         aclr;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_ax, req_ay, req_az;
    logic         res_valid;
    logic [1:0]   res_id;
    logic [31:0]  res_data;
    logic         mac_busy;
`ifdef FP_MAC_ARB_STATS_EN
    logic [127:0] issue_count;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // r0: 1.0*2.0+0.5, r1: 2.0*2.0+0.5, r2: 1.5*2.0+0.25, r3: 4.0*2.0+0.5
    logic [31:0] exp_res [4] = '{32'h4020_0000, 32'h4090_0000, 32'h4050_0000, 32'h4108_0000};
    logic [3:0]  sp_v    [6] = '{4'b1010, 4'b1010, 4'b0000, 4'b1010, 4'b1010, 4'b0000};
    logic [3:0]  sp_g    [6] = '{4'b0010, 4'b1000, 4'b0000, 4'b0010, 4'b1000, 4'b0000};
    int          sp_r    [10] = '{-1, -1, -1, -1, 1, 3, -1, 1, 3, -1};

    always #5 clk = ~clk;

    fp_mac_arbiter #(.NUM_REQ(4), .MAC_LATENCY(4)) dut (
        .clk         (clk),
        .aclr        (aclr),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_ax      (req_ax),
        .req_ay      (req_ay),
        .req_az      (req_az),
        .res_valid   (res_valid),
        .res_id      (res_id),
        .res_data    (res_data),
`ifdef FP_MAC_ARB_STATS_EN
        .issue_count (issue_count),
`endif
        .mac_busy    (mac_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    // id < 0 means no result strobe is expected this cycle
    task automatic check_res(input string tag, input int id);
        if (id < 0) begin
            check({tag, "_valid"}, 32'(res_valid), 32'd0);
        end else begin
            check({tag, "_valid"}, 32'(res_valid), 32'd1);
            check({tag, "_id"}, 32'(res_id), 32'(id));
            check({tag, "_data"}, res_data, exp_res[id]);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        aclr      = 1'b1;
        req_valid = 4'b1111;
        req_ax    = {32'h4080_0000, 32'h3FC0_0000, 32'h4000_0000, 32'h3F80_0000};
        req_ay    = {4{32'h4000_0000}};
        req_az    = {32'h3F00_0000, 32'h3E80_0000, 32'h3F00_0000, 32'h3F00_0000};

        // Reset with requests pending
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_res_data", res_data, 32'd0);
        check("rst_busy", 32'(mac_busy), 32'd0);
        req_valid = 4'b0000;
        aclr      = 1'b0;
        next_cycle();

        // Fairness: all valid for 8 cycles, first grant to requester 0
        for (int t = 0; t < 12; t++) begin
            req_valid = (t < 8) ? 4'b1111 : 4'b0000;
            #1;
            if (t < 8) check("fair_grant", 32'(req_ready), 32'd1 << (t % 4));
            if (t == 7) check("fair_busy", 32'(mac_busy), 32'd1);
            check_res("fair_res", (t >= 4) ? (t - 4) % 4 : -1);
            next_cycle();
        end
        req_valid = 4'b0000;
        #1;
        check("fair_drain_valid", 32'(res_valid), 32'd0);
        check("fair_drain_busy", 32'(mac_busy), 32'd0);

        // Sparse: requesters 1 and 3 with an idle slot
        for (int t = 0; t < 10; t++) begin
            req_valid = (t < 6) ? sp_v[t] : 4'b0000;
            #1;
            if (t < 6) check("sparse_grant", 32'(req_ready), 32'(sp_g[t]));
            check_res("sparse_res", sp_r[t]);
            next_cycle();
        end

        // Single op from requester 2: 1.5*2.0+0.25 = 3.25, strobe exactly one cycle
        for (int t = 0; t < 6; t++) begin
            req_valid = (t == 0) ? 4'b0100 : 4'b0000;
            #1;
            if (t == 0) check("single_grant", 32'(req_ready), 32'b0100);
            if (t >= 3) check_res("single_res", (t == 4) ? 2 : -1);
            next_cycle();
        end

        // Requester 1 drops as the pointer moves to it: requester 0 still gets the slot
        for (int t = 0; t < 7; t++) begin
            req_valid = (t == 0) ? 4'b0011 : (t == 1) ? 4'b0001 : 4'b0000;
            #1;
            if (t < 2) check("drop_grant", 32'(req_ready), 32'b0001);
            if (t >= 3) check_res("drop_res", (t == 4 || t == 5) ? 0 : -1);
            next_cycle();
        end

        // Reset while three ops are in flight
        for (int t = 0; t < 3; t++) begin
            req_valid = 4'b1111;
            #1;
            check("rif_grant", 32'(req_ready), 32'd2 << t);
            next_cycle();
        end
        check("rif_busy_before", 32'(mac_busy), 32'd1);
        aclr = 1'b1;
        #1;
        check("rif_ready_in_rst", 32'(req_ready), 32'd0);
        check("rif_busy_in_rst", 32'(mac_busy), 32'd0);
        check("rif_data_in_rst", res_data, 32'd0);
        next_cycle();
        aclr      = 1'b0;
        req_valid = 4'b0000;
        for (int t = 0; t < 5; t++) begin
            #1;
            check("rif_no_res", 32'(res_valid), 32'd0);
            check("rif_busy_after", 32'(mac_busy), 32'd0);
            next_cycle();
        end
        req_valid = 4'b1111;
        #1;
        check("rif_ptr_reset", 32'(req_ready), 32'b0001);
        req_valid = 4'b0000;
        next_cycle();

        // Single requester held valid: granted every cycle, results back to back
        for (int t = 0; t < 10; t++) begin
            req_valid = (t < 5) ? 4'b0010 : 4'b0000;
            #1;
            if (t < 5) check("hold_grant", 32'(req_ready), 32'b0010);
            check_res("hold_res", (t >= 4 && t <= 8) ? 1 : -1);
            next_cycle();
        end

`ifdef FP_MAC_ARB_STATS_EN
        check("stats_r0", issue_count[31:0], 32'd0);
        check("stats_r1", issue_count[63:32], 32'd5);
        check("stats_r2", issue_count[95:64], 32'd0);
        check("stats_r3", issue_count[127:96], 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fp_mac_arbiter.md
# fp_mac_arbiter

Shares one single-precision multiply-add DSP instance (`FP_MUL_ADD`, result = ax*ay + az) among `NUM_REQ` requesters, such as per-pipeline force or energy accumulators in the range-limited MD force path. It arbitrates round-robin and issues one operation per cycle into the fixed-latency DSP. An ID tag travels alongside each operation in a shift pipeline, so every result is returned with the identity of the requester that issued it.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..16.
- `MAC_LATENCY`, 4: clock edges from issue to DSP result. Must match the DSP register configuration (ax/ay/az input, mult pipeline, adder input and output registers all on clock 0).
- `ID_WIDTH`, $clog2(NUM_REQ): derived; not to be overridden.
- `clk` in 1: single clock for the block and the DSP.
- `aclr` in 1: asynchronous, active-high reset; also drives both DSP aclr bits.
- `req_valid` in NUM_REQ: per-requester operation request.
- `req_ready` out NUM_REQ: one-hot grant; transfer when `req_valid[i] & req_ready[i]`.
- `req_ax` in NUM_REQ*32: multiplicand A. Requester i occupies bits [32i+31:32i]; same packing for `req_ay` and `req_az`.
- `req_ay` in NUM_REQ*32: multiplicand B.
- `req_az` in NUM_REQ*32: addend.
- `res_valid` out 1: result strobe, one cycle; no backpressure.
- `res_id` out ID_WIDTH: requester index of the result.
- `res_data` out 32: IEEE-754 single result.
- `mac_busy` out 1: at least one operation is in flight.

## Operation
- Grant is combinational from `req_valid` and the round-robin pointer `rr_ptr`. It goes to the first valid requester at or after `rr_ptr`, searching upward with wrap, and is zero when no requester is valid.
- `req_ready` is the grant vector. `req_ready[i]` never rises without `req_valid[i]`.
- On a transfer, `rr_ptr` updates to (granted index + 1) mod NUM_REQ at the clock edge. With no transfer, `rr_ptr` holds.
- The granted requester's operands are muxed combinationally onto DSP `ax`, `ay` and `az`; the DSP input registers capture them.
- With no grant, the mux drives zeros and the slot is tagged invalid.
- DSP `ena` is tied to 1, so latency is fixed and the pipeline never stalls.
- Tag pipeline: `MAC_LATENCY` stages of {valid, id}. Stage 0 loads {transfer, granted index} every cycle and each stage shifts every cycle.
- `res_valid` and `res_id` come from the last tag stage; `res_data` comes from DSP `resulta`.
- `mac_busy` is the OR of all tag-stage valid bits.
- Arithmetic, rounding, and inf/NaN handling are exactly those of the DSP; the block never inspects operand values.
- Reset mid-operation clears all tags. In-flight operations are discarded and produce no `res_valid`.

## Timing
- Reset values: `req_ready`=0 while `aclr` is high, `res_valid`=0, `res_id`=0, `res_data`=0 (DSP output cleared), `mac_busy`=0, `rr_ptr`=0.
- Latency: operation accepted at edge k gives `res_valid`=1 in the cycle after edge k+MAC_LATENCY-1, i.e. valid MAC_LATENCY cycles after the accept cycle.
- Throughput: one accept per cycle sustained. Back-to-back accepts give back-to-back results in issue order.
- All-requesters-valid: grants rotate 0,1,2,3,0,... with exactly one grant per cycle.
- Single requester held valid: granted every cycle.
- A requester's `req_valid` dropping in the same cycle as the pointer update causes no grant to it and no lost slot.

## Configuration
- `FP_MAC_ARB_STATS_EN`:
  - Defined: adds output `issue_count` (NUM_REQ*32) with one saturating 32-bit counter per requester, incremented on each transfer and cleared by `aclr`.
  - Undefined: the port and the counters are absent; all other behaviour is identical.

## Structure
- Shared package `fp_mac_arb_pkg`: `FP_W`=32, `MAC_LATENCY_DEFAULT`=4, and the tag struct typedef {valid, id}.
- Sub-module `fp_mac_rr_arbiter` holds the combinational grant and `rr_ptr` register, parameterised on NUM_REQ.
- The top instantiates `fp_mac_rr_arbiter`, the operand mux, the tag shift pipeline and `FP_MUL_ADD`.

## Test plan
- Reset: assert `aclr` with requests pending -> all outputs 0 and `req_ready`=0; release -> first grant goes to requester 0.
- Single op: requester 2 issues ax=0x3FC00000 (1.5), ay=0x40000000 (2.0), az=0x3E800000 (0.25) -> after 4 cycles `res_valid`=1, `res_id`=2, `res_data`=0x40500000 (3.25), held for exactly one cycle.
- Fairness: all 4 requesters valid for 8 cycles -> grants 0,1,2,3,0,1,2,3; results come back in the same id order with no gaps.
- Sparse: only requesters 1 and 3 valid -> grants alternate 1,3,1,3; idle slots produce no `res_valid`.
- Reset in flight: 3 ops accepted, then `aclr` pulses for one cycle -> no `res_valid` from those ops; `mac_busy`=0 after reset.
- Stats (with `FP_MAC_ARB_STATS_EN`): 5 issues from requester 1 -> `issue_count[63:32]`=5, all other counters 0.
